// File: rtl/pipe_ctrl_fsm_pkg.sv
// Shared types for the pipeline stall/flush sequencer: stall bus encodings,
// FSM state encoding and the request-priority encoder.
package pipe_ctrl_fsm_pkg;

   localparam int STALL_BUS_W = 6;
   typedef logic [STALL_BUS_W-1:0] stall_bus_t;

   // Bit0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB; a set bit holds that stage
   localparam stall_bus_t STALL_NONE = 6'b000000;
   localparam stall_bus_t STALL_ID   = 6'b000111;
   localparam stall_bus_t STALL_EX   = 6'b001111;
   localparam stall_bus_t STALL_MEM  = 6'b011111;

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_PEND  = 2'd1,
      S_FLUSH = 2'd2
   } state_e;

   function automatic stall_bus_t stall_encode(input logic id, input logic ex, input logic mem);
      stall_bus_t s;
      if (mem)     s = STALL_MEM;
      else if (ex) s = STALL_EX;
      else if (id) s = STALL_ID;
      else         s = STALL_NONE;
      return s;
   endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Stall-cycle and flush-event counters; only instantiated when the
// PIPE_CTRL_PERF_CNT_EN build option is defined.
module pipe_perf_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        perf_clr,
   input  logic        stall_active,
   input  logic        flush_entry,
   output logic [31:0] stall_cyc_cnt,
   output logic [15:0] flush_evt_cnt
);

   logic [31:0] stall_cyc_cnt_q, stall_cyc_cnt_d;
   logic [15:0] flush_evt_cnt_q, flush_evt_cnt_d;

   // Clear wins over a same-cycle increment; both counters wrap naturally
   always_comb begin
      stall_cyc_cnt_d = stall_cyc_cnt_q;
      flush_evt_cnt_d = flush_evt_cnt_q;
      if (perf_clr) begin
         stall_cyc_cnt_d = '0;
         flush_evt_cnt_d = '0;
      end else begin
         if (stall_active) stall_cyc_cnt_d = stall_cyc_cnt_q + 32'd1;
         if (flush_entry)  flush_evt_cnt_d = flush_evt_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cyc_cnt_q <= '0;
         flush_evt_cnt_q <= '0;
      end else begin
         stall_cyc_cnt_q <= stall_cyc_cnt_d;
         flush_evt_cnt_q <= flush_evt_cnt_d;
      end
   end

   assign stall_cyc_cnt = stall_cyc_cnt_q;
   assign flush_evt_cnt = flush_evt_cnt_q;

endmodule

// File: rtl/pipe_ctrl_fsm.sv
// Pipeline stall/flush sequencer. Defining PIPE_CTRL_PERF_CNT_EN adds the
// perf_clr input and the stall_cyc_cnt / flush_evt_cnt counter outputs.
module pipe_ctrl_fsm
   import pipe_ctrl_fsm_pkg::*;
#(
   parameter int STALL_W   = 6,
   parameter int PC_W      = 32,
   parameter int FLUSH_CYC = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stallreq_from_id,
   input  logic               stallreq_from_ex,
   input  logic               stallreq_from_mem,
   input  logic               excp_valid,
   input  logic [PC_W-1:0]    excp_new_pc,
   output logic [STALL_W-1:0] stall,
   output logic               flush,
   output logic [PC_W-1:0]    new_pc,
   output logic               ctrl_busy
`ifdef PIPE_CTRL_PERF_CNT_EN
   ,
   input  logic               perf_clr,
   output logic [31:0]        stall_cyc_cnt,
   output logic [15:0]        flush_evt_cnt
`endif
);

   localparam int CNT_W = 3;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYC - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
   logic              flush_q, flush_d;
   logic [PC_W-1:0]   new_pc_q, new_pc_d;
   logic              busy_q, busy_d;
   stall_bus_t        stall_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_RUN;
         flush_cnt_q <= '0;
         pend_pc_q   <= '0;
         flush_q     <= 1'b0;
         new_pc_q    <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         pend_pc_q   <= pend_pc_d;
         flush_q     <= flush_d;
         new_pc_q    <= new_pc_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      pend_pc_d   = pend_pc_q;
      unique case (state_q)
         S_RUN: begin
            if (excp_valid) begin
               pend_pc_d = excp_new_pc;
               state_d   = stallreq_from_mem ? S_PEND : S_FLUSH;
            end
         end
         // Later redirects are dropped: the first one captured is the precise one
         S_PEND: begin
            if (!stallreq_from_mem) state_d = S_FLUSH;
         end
         S_FLUSH: begin
            if (flush_cnt_q == CNT_LAST) begin
               flush_cnt_d = '0;
               state_d     = S_RUN;
            end else begin
               flush_cnt_d = flush_cnt_q + 1'b1;
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   // Registered outputs are decoded from the next state so they line up with state_q
   always_comb begin
      flush_d  = (state_d == S_FLUSH);
      busy_d   = (state_d != S_RUN);
      new_pc_d = new_pc_q;
      if (state_d == S_FLUSH) new_pc_d = pend_pc_d;
      unique case (state_q)
         S_RUN:   stall_c = stall_encode(stallreq_from_id, stallreq_from_ex, stallreq_from_mem);
         S_PEND:  stall_c = STALL_MEM;
         default: stall_c = STALL_NONE;
      endcase
   end

   assign stall     = stall_c;
   assign flush     = flush_q;
   assign new_pc    = new_pc_q;
   assign ctrl_busy = busy_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
   pipe_perf_cnt u_perf (
      .clk           (clk),
      .rst           (rst),
      .perf_clr      (perf_clr),
      .stall_active  (stall_c != STALL_NONE),
      .flush_entry   ((state_d == S_FLUSH) && (state_q != S_FLUSH)),
      .stall_cyc_cnt (stall_cyc_cnt),
      .flush_evt_cnt (flush_evt_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_ctrl_fsm.sv
// Directed bench for pipe_ctrl_fsm: one instance with a single-cycle flush,
// one with a three-cycle flush, both driven by the same stimulus.
module tb_pipe_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_r, ex_r, mem_r, ev;
   logic [31:0] epc;
   logic [5:0]  stall1, stall3;
   logic        flush1, flush3, busy1, busy3;
   logic [31:0] npc1, npc3;
   int          n_cmp = 0;
   int          n_err = 0;
`ifdef PIPE_CTRL_PERF_CNT_EN
   logic        perf_clr;
   logic [31:0] scc1, scc3;
   logic [15:0] fec1, fec3;
`endif

   always #5 clk = ~clk;

   pipe_ctrl_fsm #(.STALL_W(6), .PC_W(32), .FLUSH_CYC(1)) dut1 (
      .clk(clk), .rst(rst),
      .stallreq_from_id(id_r), .stallreq_from_ex(ex_r), .stallreq_from_mem(mem_r),
      .excp_valid(ev), .excp_new_pc(epc),
      .stall(stall1), .flush(flush1), .new_pc(npc1), .ctrl_busy(busy1)
`ifdef PIPE_CTRL_PERF_CNT_EN
      , .perf_clr(perf_clr), .stall_cyc_cnt(scc1), .flush_evt_cnt(fec1)
`endif
   );

   pipe_ctrl_fsm #(.STALL_W(6), .PC_W(32), .FLUSH_CYC(3)) dut3 (
      .clk(clk), .rst(rst),
      .stallreq_from_id(id_r), .stallreq_from_ex(ex_r), .stallreq_from_mem(mem_r),
      .excp_valid(ev), .excp_new_pc(epc),
      .stall(stall3), .flush(flush3), .new_pc(npc3), .ctrl_busy(busy3)
`ifdef PIPE_CTRL_PERF_CNT_EN
      , .perf_clr(perf_clr), .stall_cyc_cnt(scc3), .flush_evt_cnt(fec3)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      id_r = 0; ex_r = 0; mem_r = 0; ev = 0; epc = '0;
      repeat (n) tick();
   endtask

   task automatic test_reset();
      rst = 1; id_r = 0; ex_r = 0; mem_r = 0; ev = 0; epc = '0;
`ifdef PIPE_CTRL_PERF_CNT_EN
      perf_clr = 0;
`endif
      #12;
      n_cmp++; if ({stall1, flush1, npc1, busy1} !== 39'd0) begin n_err++;
         $display("FAIL reset_dut1: got stall=%b flush=%b new_pc=%h busy=%b want all 0", stall1, flush1, npc1, busy1); end
      n_cmp++; if ({stall3, flush3, npc3, busy3} !== 39'd0) begin n_err++;
         $display("FAIL reset_dut3: got stall=%b flush=%b new_pc=%h busy=%b want all 0", stall3, flush3, npc3, busy3); end
      tick();
      rst = 0;
      tick();
   endtask

   task automatic test_stall_prio();
      id_r = 1; #1;
      n_cmp++; if (stall1 !== 6'b000111) begin n_err++; $display("FAIL stall_id: got %b want 000111", stall1); end
      ex_r = 1; #1;
      n_cmp++; if (stall1 !== 6'b001111) begin n_err++; $display("FAIL stall_ex: got %b want 001111", stall1); end
      mem_r = 1; #1;
      n_cmp++; if (stall1 !== 6'b011111) begin n_err++; $display("FAIL stall_mem: got %b want 011111", stall1); end
      id_r = 0; ex_r = 0; #1;
      n_cmp++; if (stall3 !== 6'b011111) begin n_err++; $display("FAIL stall_mem_only: got %b want 011111", stall3); end
      tick();
      n_cmp++; if ({flush1, busy1} !== 2'b00) begin n_err++; $display("FAIL stall_no_flush: got flush=%b busy=%b want 0 0", flush1, busy1); end
      mem_r = 0; #1;
      n_cmp++; if (stall1 !== 6'b000000) begin n_err++; $display("FAIL stall_none: got %b want 000000", stall1); end
      idle(2);
   endtask

   task automatic test_redirect();
      ev = 1; epc = 32'hBFC00380;
      tick();
      ev = 0; epc = 32'h0; id_r = 1; #1;
      n_cmp++; if (flush1 !== 1'b1) begin n_err++; $display("FAIL redir_flush: got %b want 1", flush1); end
      n_cmp++; if (npc1 !== 32'hBFC00380) begin n_err++; $display("FAIL redir_pc: got %h want bfc00380", npc1); end
      n_cmp++; if (stall1 !== 6'b000000) begin n_err++; $display("FAIL redir_stall_override: got %b want 000000", stall1); end
      n_cmp++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL redir_busy: got %b want 1", busy1); end
      tick();
      n_cmp++; if ({flush1, busy1} !== 2'b00) begin n_err++; $display("FAIL redir_one_cycle: got flush=%b busy=%b want 0 0", flush1, busy1); end
      n_cmp++; if (stall1 !== 6'b000111) begin n_err++; $display("FAIL redir_back_to_run: got %b want 000111", stall1); end
      n_cmp++; if (npc1 !== 32'hBFC00380) begin n_err++; $display("FAIL redir_pc_hold: got %h want bfc00380", npc1); end
      idle(5);
   endtask

   task automatic test_pend();
      ev = 1; epc = 32'h80000180; mem_r = 1; #1;
      n_cmp++; if (stall1 !== 6'b011111) begin n_err++; $display("FAIL pend_c0_stall: got %b want 011111", stall1); end
      for (int c = 1; c < 4; c++) begin
         tick();
         ev = (c == 2); epc = (c == 2) ? 32'h1234 : 32'h0; #1;
         n_cmp++; if (stall1 !== 6'b011111) begin n_err++; $display("FAIL pend_hold_stall c%0d: got %b want 011111", c, stall1); end
         n_cmp++; if ({flush1, busy1} !== 2'b01) begin n_err++; $display("FAIL pend_hold_ctl c%0d: got flush=%b busy=%b want 0 1", c, flush1, busy1); end
      end
      tick();
      ev = 0; epc = '0; mem_r = 0; #1;
      n_cmp++; if (stall1 !== 6'b011111) begin n_err++; $display("FAIL pend_drop_stall: got %b want 011111", stall1); end
      n_cmp++; if (flush1 !== 1'b0) begin n_err++; $display("FAIL pend_drop_flush: got %b want 0", flush1); end
      tick();
      n_cmp++; if (flush1 !== 1'b1) begin n_err++; $display("FAIL pend_flush: got %b want 1", flush1); end
      n_cmp++; if (npc1 !== 32'h80000180) begin n_err++; $display("FAIL pend_first_wins: got %h want 80000180", npc1); end
      tick();
      n_cmp++; if ({flush1, busy1} !== 2'b00) begin n_err++; $display("FAIL pend_done: got flush=%b busy=%b want 0 0", flush1, busy1); end
      idle(5);
   endtask

   task automatic test_flush_multi();
      ev = 1; epc = 32'hCAFE0000; ex_r = 1; #1;
      n_cmp++; if (stall3 !== 6'b001111) begin n_err++; $display("FAIL fm_same_cycle_stall: got %b want 001111", stall3); end
      tick();
      ev = 0; epc = '0;
      for (int c = 0; c < 3; c++) begin
         n_cmp++; if ({flush3, busy3, stall3} !== {2'b11, 6'b000000}) begin n_err++;
            $display("FAIL fm_cycle%0d: got flush=%b busy=%b stall=%b want 1 1 000000", c, flush3, busy3, stall3); end
         n_cmp++; if (npc3 !== 32'hCAFE0000) begin n_err++; $display("FAIL fm_pc%0d: got %h want cafe0000", c, npc3); end
         tick();
      end
      n_cmp++; if ({flush3, busy3, stall3} !== {2'b00, 6'b001111}) begin n_err++;
         $display("FAIL fm_end: got flush=%b busy=%b stall=%b want 0 0 001111", flush3, busy3, stall3); end
      idle(5);
   endtask

   task automatic test_reset_mid_flush();
      ev = 1; epc = 32'h00400000;
      tick();
      ev = 0; epc = '0; mem_r = 1;
      tick();
      n_cmp++; if (flush3 !== 1'b1) begin n_err++; $display("FAIL rmf_in_flush: got %b want 1", flush3); end
      rst = 1; #1;
      n_cmp++; if ({flush3, busy3, npc3} !== 34'd0) begin n_err++;
         $display("FAIL rmf_async: got flush=%b busy=%b new_pc=%h want 0 0 0", flush3, busy3, npc3); end
      n_cmp++; if (stall3 !== 6'b011111) begin n_err++; $display("FAIL rmf_run_stall: got %b want 011111", stall3); end
      mem_r = 0; #1;
      n_cmp++; if (stall3 !== 6'b000000) begin n_err++; $display("FAIL rmf_stall: got %b want 000000", stall3); end
      #2 rst = 0;
      tick();
      n_cmp++; if ({flush3, busy3} !== 2'b00) begin n_err++; $display("FAIL rmf_after: got flush=%b busy=%b want 0 0", flush3, busy3); end
      idle(3);
   endtask

`ifdef PIPE_CTRL_PERF_CNT_EN
   task automatic test_perf();
      perf_clr = 1; tick(); perf_clr = 0;
      id_r = 1; repeat (5) tick(); id_r = 0;
      n_cmp++; if (scc1 !== 32'd5) begin n_err++; $display("FAIL perf_stall_cnt: got %0d want 5", scc1); end
      repeat (2) begin
         ev = 1; epc = 32'h100; tick(); ev = 0; tick(); tick();
      end
      n_cmp++; if (scc1 !== 32'd5) begin n_err++; $display("FAIL perf_stall_cnt2: got %0d want 5", scc1); end
      n_cmp++; if (fec1 !== 16'd2) begin n_err++; $display("FAIL perf_flush_cnt: got %0d want 2", fec1); end
      perf_clr = 1; tick(); perf_clr = 0;
      n_cmp++; if ({scc1, fec1} !== 48'd0) begin n_err++; $display("FAIL perf_clr: got %0d %0d want 0 0", scc1, fec1); end
      idle(3);
   endtask
`endif

   initial begin
      test_reset();
      test_stall_prio();
      test_redirect();
      test_pend();
      test_flush_multi();
      test_reset_mid_flush();
`ifdef PIPE_CTRL_PERF_CNT_EN
      test_perf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
